swap_seq: RTL and testbench

- Registered swap/move sequencer for the SISC datapath. Replaces the combinational single-word swap select.
- On a start pulse it captures two register-file operands and their addresses.
- It then drives the register-file write port over one or two cycles to perform swap, copy-A-to-B or copy-B-to-A.
- Sits between the control unit (start/op, busy/done) and the register-file write-port mux.

---
 rtl/sisc_swap_pkg.sv | 44 ++++
 rtl/swap_wport_sel.sv | 43 ++++
 rtl/swap_seq.sv | 88 ++++++++
 tb/tb_swap_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_swap_pkg.sv
// Shared definitions for the SISC swap/move sequencer: op codes, FSM state encoding,
// default widths and the next-state function used by swap_seq.
package sisc_swap_pkg;

    localparam int SWP_DATA_W = 32;
    localparam int SWP_ADDR_W = 4;
    localparam int SWP_OP_W   = 2;

    localparam logic [1:0] SWP_OP_SWAP    = 2'b00;
    localparam logic [1:0] SWP_OP_COPY_AB = 2'b01;
    localparam logic [1:0] SWP_OP_COPY_BA = 2'b10;
    localparam logic [1:0] SWP_OP_NOP     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WR_A = 2'b01,
        ST_WR_B = 2'b10,
        ST_FIN  = 2'b11
    } swp_state_t;

    // In IDLE the fresh op decides the path; afterwards only the captured op matters.
    function automatic swp_state_t swp_next_state(input swp_state_t st, input logic start,
                                                  input logic [1:0] op_new, input logic [1:0] op_cap);
        swp_state_t nxt;
        nxt = st;
        case (st)
            ST_IDLE: begin
                if (start) begin
                    case (op_new)
                        SWP_OP_SWAP:    nxt = ST_WR_A;
                        SWP_OP_COPY_AB: nxt = ST_WR_B;
                        SWP_OP_COPY_BA: nxt = ST_WR_A;
                        default:        nxt = ST_FIN;
                    endcase
                end
            end
            ST_WR_A: nxt = (op_cap == SWP_OP_SWAP) ? ST_WR_B : ST_FIN;
            ST_WR_B: nxt = ST_FIN;
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/swap_wport_sel.sv
// Write-port select for the swap sequencer: picks address/data for the state being entered.
// With SWAP_SEQ_R0_PROTECT_EN defined, writes targeting address 0 are suppressed.
module swap_wport_sel
    import sisc_swap_pkg::*;
#(
    parameter int DATA_W = SWP_DATA_W,
    parameter int ADDR_W = SWP_ADDR_W
) (
    input  swp_state_t        nxt,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
);

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        case (nxt)
            ST_WR_A: begin
                we    = 1'b1;
                waddr = a_addr;
                wdata = b_data;
            end
            ST_WR_B: begin
                we    = 1'b1;
                waddr = b_addr;
                wdata = a_data;
            end
            default: ;
        endcase
`ifdef SWAP_SEQ_R0_PROTECT_EN
        if (waddr == '0) begin
            we = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/swap_seq.sv
// Registered swap/move sequencer driving the register-file write port over one or two cycles.
// Optional build macro SWAP_SEQ_R0_PROTECT_EN suppresses writes to address 0 (see swap_wport_sel).
module swap_seq
    import sisc_swap_pkg::*;
#(
    parameter int DATA_W = SWP_DATA_W,
    parameter int ADDR_W = SWP_ADDR_W,
    parameter int OP_W   = SWP_OP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              busy,
    output logic              done
);

    swp_state_t        state;
    swp_state_t        nxt;
    logic [1:0]        op_cap;
    logic [ADDR_W-1:0] a_cap;
    logic [ADDR_W-1:0] b_cap;
    logic [DATA_W-1:0] a_dcap;
    logic [DATA_W-1:0] b_dcap;
    logic              accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_waddr;
    logic [DATA_W-1:0] sel_wdata;

    assign accept = (state == ST_IDLE) && start;
    assign nxt    = swp_next_state(state, start, op[1:0], op_cap);

    // On the accept edge the capture registers are not loaded yet, so select from the live inputs.
    swap_wport_sel #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_sel (
        .nxt   (nxt),
        .a_addr(accept ? a_addr : a_cap),
        .b_addr(accept ? b_addr : b_cap),
        .a_data(accept ? a_data : a_dcap),
        .b_data(accept ? b_data : b_dcap),
        .we    (sel_we),
        .waddr (sel_waddr),
        .wdata (sel_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            op_cap   <= '0;
            a_cap    <= '0;
            b_cap    <= '0;
            a_dcap   <= '0;
            b_dcap   <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                op_cap <= op[1:0];
                a_cap  <= a_addr;
                b_cap  <= b_addr;
                a_dcap <= a_data;
                b_dcap <= b_data;
            end
            rf_we <= sel_we;
            // Address and data hold their last value whenever no write is issued.
            if (sel_we) begin
                rf_waddr <= sel_waddr;
                rf_wdata <= sel_wdata;
            end
            busy <= (nxt != ST_IDLE);
            done <= (nxt == ST_FIN);
        end
    end

endmodule

// File: tb/tb_swap_seq.sv
// Directed self-checking bench for swap_seq; each task checks one scenario cycle by cycle.
module tb_swap_seq;
    import sisc_swap_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  a_addr;
    logic [3:0]  b_addr;
    logic [31:0] a_data;
    logic [31:0] b_data;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;
    logic        done;
    logic [38:0] obs;

    int nchecks = 0;
    int nerrors = 0;

    swap_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a_addr  (a_addr),
        .b_addr  (b_addr),
        .a_data  (a_data),
        .b_data  (b_data),
        .rf_we   (rf_we),
        .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Observation word: {we, waddr, wdata, busy, done}
    assign obs = {rf_we, rf_waddr, rf_wdata, busy, done};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [3:0] aa, input logic [3:0] ba,
                         input logic [31:0] ad, input logic [31:0] bd);
        start  = 1'b1;
        op     = o;
        a_addr = aa;
        b_addr = ba;
        a_data = ad;
        b_data = bd;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00;
        a_addr = 4'd0; b_addr = 4'd0; a_data = 32'h0; b_data = 32'h0;
        step(); step();
        nchecks++;
        if (obs !== 39'd0) begin
            nerrors++; $display("[TB] FAIL reset_outputs: got %h expected %h", obs, 39'd0);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_swap();
        issue(2'b00, 4'd3, 4'd7, 32'h11111111, 32'h22222222);
        nchecks++;
        if (obs !== {1'b1, 4'd3, 32'h22222222, 1'b1, 1'b0}) begin
            nerrors++; $display("[TB] FAIL swap_c1: got %h expected %h", obs, {1'b1, 4'd3, 32'h22222222, 1'b1, 1'b0});
        end
        step();
        nchecks++;
        if (obs !== {1'b1, 4'd7, 32'h11111111, 1'b1, 1'b0}) begin
            nerrors++; $display("[TB] FAIL swap_c2: got %h expected %h", obs, {1'b1, 4'd7, 32'h11111111, 1'b1, 1'b0});
        end
        step();
        nchecks++;
        if (obs !== {1'b0, 4'd7, 32'h11111111, 1'b1, 1'b1}) begin
            nerrors++; $display("[TB] FAIL swap_c3_done: got %h expected %h", obs, {1'b0, 4'd7, 32'h11111111, 1'b1, 1'b1});
        end
        step();
        nchecks++;
        if (obs !== {1'b0, 4'd7, 32'h11111111, 1'b0, 1'b0}) begin
            nerrors++; $display("[TB] FAIL swap_c4_idle: got %h expected %h", obs, {1'b0, 4'd7, 32'h11111111, 1'b0, 1'b0});
        end
    endtask

    task automatic test_copy();
        issue(2'b01, 4'd2, 4'd5, 32'hDEADBEEF, 32'h55555555);
        nchecks++;
        if (obs !== {1'b1, 4'd5, 32'hDEADBEEF, 1'b1, 1'b0}) begin
            nerrors++; $display("[TB] FAIL copy_ab_c1: got %h expected %h", obs, {1'b1, 4'd5, 32'hDEADBEEF, 1'b1, 1'b0});
        end
        step();
        nchecks++;
        if (obs !== {1'b0, 4'd5, 32'hDEADBEEF, 1'b1, 1'b1}) begin
            nerrors++; $display("[TB] FAIL copy_ab_c2_done: got %h expected %h", obs, {1'b0, 4'd5, 32'hDEADBEEF, 1'b1, 1'b1});
        end
        step();
        nchecks++;
        if (obs !== {1'b0, 4'd5, 32'hDEADBEEF, 1'b0, 1'b0}) begin
            nerrors++; $display("[TB] FAIL copy_ab_c3_idle: got %h expected %h", obs, {1'b0, 4'd5, 32'hDEADBEEF, 1'b0, 1'b0});
        end
        issue(2'b10, 4'd6, 4'd9, 32'h12345678, 32'hCAFEF00D);
        nchecks++;
        if (obs !== {1'b1, 4'd6, 32'hCAFEF00D, 1'b1, 1'b0}) begin
            nerrors++; $display("[TB] FAIL copy_ba_c1: got %h expected %h", obs, {1'b1, 4'd6, 32'hCAFEF00D, 1'b1, 1'b0});
        end
        step();
        nchecks++;
        if (obs !== {1'b0, 4'd6, 32'hCAFEF00D, 1'b1, 1'b1}) begin
            nerrors++; $display("[TB] FAIL copy_ba_c2_done: got %h expected %h", obs, {1'b0, 4'd6, 32'hCAFEF00D, 1'b1, 1'b1});
        end
        step();
    endtask

    task automatic test_nop();
        issue(2'b11, 4'd1, 4'd2, 32'hFFFFFFFF, 32'hEEEEEEEE);
        nchecks++;
        if (obs !== {1'b0, 4'd6, 32'hCAFEF00D, 1'b1, 1'b1}) begin
            nerrors++; $display("[TB] FAIL nop_c1_done: got %h expected %h", obs, {1'b0, 4'd6, 32'hCAFEF00D, 1'b1, 1'b1});
        end
        step();
        nchecks++;
        if (obs !== {1'b0, 4'd6, 32'hCAFEF00D, 1'b0, 1'b0}) begin
            nerrors++; $display("[TB] FAIL nop_c2_idle: got %h expected %h", obs, {1'b0, 4'd6, 32'hCAFEF00D, 1'b0, 1'b0});
        end
    endtask

    task automatic test_capture();
        issue(2'b00, 4'd1, 4'd2, 32'hAAAAAAAA, 32'hBBBBBBBB);
        a_data = 32'h0; b_data = 32'h0; a_addr = 4'd0; b_addr = 4'd0;
        nchecks++;
        if (obs !== {1'b1, 4'd1, 32'hBBBBBBBB, 1'b1, 1'b0}) begin
            nerrors++; $display("[TB] FAIL capture_c1: got %h expected %h", obs, {1'b1, 4'd1, 32'hBBBBBBBB, 1'b1, 1'b0});
        end
        step();
        nchecks++;
        if (obs !== {1'b1, 4'd2, 32'hAAAAAAAA, 1'b1, 1'b0}) begin
            nerrors++; $display("[TB] FAIL capture_c2: got %h expected %h", obs, {1'b1, 4'd2, 32'hAAAAAAAA, 1'b1, 1'b0});
        end
        step(); step();
    endtask

    task automatic test_same_addr();
        issue(2'b00, 4'd8, 4'd8, 32'h01020304, 32'h0A0B0C0D);
        nchecks++;
        if (obs !== {1'b1, 4'd8, 32'h0A0B0C0D, 1'b1, 1'b0}) begin
            nerrors++; $display("[TB] FAIL same_addr_c1: got %h expected %h", obs, {1'b1, 4'd8, 32'h0A0B0C0D, 1'b1, 1'b0});
        end
        step();
        nchecks++;
        if (obs !== {1'b1, 4'd8, 32'h01020304, 1'b1, 1'b0}) begin
            nerrors++; $display("[TB] FAIL same_addr_c2: got %h expected %h", obs, {1'b1, 4'd8, 32'h01020304, 1'b1, 1'b0});
        end
        step(); step();
    endtask

    task automatic test_back_to_back();
        start = 1'b1; op = 2'b00;
        a_addr = 4'd10; b_addr = 4'd11; a_data = 32'h10101010; b_data = 32'h20202020;
        step();
        nchecks++;
        if (obs !== {1'b1, 4'd10, 32'h20202020, 1'b1, 1'b0}) begin
            nerrors++; $display("[TB] FAIL held_c1: got %h expected %h", obs, {1'b1, 4'd10, 32'h20202020, 1'b1, 1'b0});
        end
        // New values while busy must not be picked up by the running operation.
        a_addr = 4'd12; b_addr = 4'd13; a_data = 32'h30303030; b_data = 32'h40404040;
        step();
        nchecks++;
        if (obs !== {1'b1, 4'd11, 32'h10101010, 1'b1, 1'b0}) begin
            nerrors++; $display("[TB] FAIL held_c2: got %h expected %h", obs, {1'b1, 4'd11, 32'h10101010, 1'b1, 1'b0});
        end
        step();
        nchecks++;
        if (obs !== {1'b0, 4'd11, 32'h10101010, 1'b1, 1'b1}) begin
            nerrors++; $display("[TB] FAIL held_c3_done: got %h expected %h", obs, {1'b0, 4'd11, 32'h10101010, 1'b1, 1'b1});
        end
        step();
        nchecks++;
        if (obs !== {1'b0, 4'd11, 32'h10101010, 1'b0, 1'b0}) begin
            nerrors++; $display("[TB] FAIL held_c4_idle: got %h expected %h", obs, {1'b0, 4'd11, 32'h10101010, 1'b0, 1'b0});
        end
        step();
        start = 1'b0;
        nchecks++;
        if (obs !== {1'b1, 4'd12, 32'h40404040, 1'b1, 1'b0}) begin
            nerrors++; $display("[TB] FAIL held_reaccept: got %h expected %h", obs, {1'b1, 4'd12, 32'h40404040, 1'b1, 1'b0});
        end
        step(); step(); step();
    endtask

    task automatic test_reset_mid();
        issue(2'b00, 4'd4, 4'd5, 32'h44444444, 32'h55555555);
        nchecks++;
        if (obs !== {1'b1, 4'd4, 32'h55555555, 1'b1, 1'b0}) begin
            nerrors++; $display("[TB] FAIL rst_mid_c1: got %h expected %h", obs, {1'b1, 4'd4, 32'h55555555, 1'b1, 1'b0});
        end
        rst = 1'b1;
        step();
        nchecks++;
        if (obs !== 39'd0) begin
            nerrors++; $display("[TB] FAIL rst_mid_cleared: got %h expected %h", obs, 39'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            nchecks++;
            if (obs !== 39'd0) begin
                nerrors++; $display("[TB] FAIL rst_mid_quiet: cycle %0d got %h expected %h", i, obs, 39'd0);
            end
        end
    endtask

    task automatic test_r0();
        issue(2'b00, 4'd0, 4'd4, 32'h0A0A0A0A, 32'h0B0B0B0B);
`ifdef SWAP_SEQ_R0_PROTECT_EN
        nchecks++;
        if ({rf_we, busy, done} !== 3'b010) begin
            nerrors++; $display("[TB] FAIL r0_c1_suppressed: got %b expected %b", {rf_we, busy, done}, 3'b010);
        end
`else
        nchecks++;
        if (obs !== {1'b1, 4'd0, 32'h0B0B0B0B, 1'b1, 1'b0}) begin
            nerrors++; $display("[TB] FAIL r0_c1_written: got %h expected %h", obs, {1'b1, 4'd0, 32'h0B0B0B0B, 1'b1, 1'b0});
        end
`endif
        step();
        nchecks++;
        if (obs !== {1'b1, 4'd4, 32'h0A0A0A0A, 1'b1, 1'b0}) begin
            nerrors++; $display("[TB] FAIL r0_c2: got %h expected %h", obs, {1'b1, 4'd4, 32'h0A0A0A0A, 1'b1, 1'b0});
        end
        step();
        nchecks++;
        if (obs !== {1'b0, 4'd4, 32'h0A0A0A0A, 1'b1, 1'b1}) begin
            nerrors++; $display("[TB] FAIL r0_c3_done: got %h expected %h", obs, {1'b0, 4'd4, 32'h0A0A0A0A, 1'b1, 1'b1});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_swap();
        test_copy();
        test_nop();
        test_capture();
        test_same_addr();
        test_back_to_back();
        test_reset_mid();
        test_r0();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
